// File: rtl/edu_round_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// edu_round_ctrl_pkg
// Shared types and helpers for the EDU round sequencer.
//   - eductrl_state_e : FSM state encoding (3-bit, EDUCTRL_* names)
//   - eductrl_out_t   : bundle of the Moore phase strobes
//   - eductrl_decode  : state -> strobe decode, used to register the outputs
//   - eductrl_cnt_w   : width of the shared GEN/timeout cycle counter
// -----------------------------------------------------------------------------
package edu_round_ctrl_pkg;

  typedef enum logic [2:0] {
    EDUCTRL_IDLE  = 3'd0,
    EDUCTRL_LOAD  = 3'd1,
    EDUCTRL_CHECK = 3'd2,
    EDUCTRL_FIRE  = 3'd3,
    EDUCTRL_PROP  = 3'd4,
    EDUCTRL_GEN   = 3'd5,
    EDUCTRL_DONE  = 3'd6
  } eductrl_state_e;

  typedef struct packed {
    logic syn_ready;
    logic spike_fire;
    logic syndrome_taken;
    logic busy;
    logic done;
  } eductrl_out_t;

  // Strobes are a pure function of the state the FSM is entering, so they
  // can be registered alongside the state and come out glitch-free.
  function automatic eductrl_out_t eductrl_decode(input eductrl_state_e s);
    eductrl_out_t o;
    o                = '0;
    o.syn_ready      = (s == EDUCTRL_LOAD);
    o.spike_fire     = (s == EDUCTRL_FIRE);
    o.syndrome_taken = (s == EDUCTRL_GEN);
    o.busy           = (s != EDUCTRL_IDLE);
    o.done           = (s == EDUCTRL_DONE);
    return o;
  endfunction

  // The counter holds at most max(a,b)-1; keep at least one bit.
  function automatic int eductrl_cnt_w(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edu_round_cnt.sv
// -----------------------------------------------------------------------------
// edu_round_cnt
// Loadable down-counter with terminal-count flag. Used by the round sequencer
// both for the syndrome-generation hold time and for the spike timeout.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   i_clr     : synchronous clear to zero
//   i_load    : load i_ld_val (wins over clear and enable)
//   i_ld_val  : value to load, i.e. cycles-to-run minus one
//   i_en      : decrement, stops at zero
//   o_tc      : count is zero (last cycle of the loaded interval)
// -----------------------------------------------------------------------------
module edu_round_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_ld_val;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/edu_round_ctrl.sv
// -----------------------------------------------------------------------------
// edu_round_ctrl
// Per-round sequencer for the EDU cell array: accepts a syndrome frame, fires
// spikes into the mesh, waits for a spike to be taken, then strobes
// syndrome_taken for GEN_CYC cycles, repeating until the mesh reports all
// syndromes cleared. Sole driver of the mesh phase strobes.
//
// Optional feature macro: EDU_TIMEOUT_EN -- bounds the PROP wait to
// MAX_SPIKE_CYC cycles and raises the sticky err_timeout flag on expiry.
// Without it err_timeout is tied low and no timeout logic exists.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : begin a round (IDLE only)
//   flush            : synchronous abort to IDLE, highest priority
//   syn_valid/ready  : frame handshake with the front end (ready in LOAD)
//   all_clear        : mesh has no non-trivial syndrome left
//   spike_taken      : mesh reports a spike was taken (PROP only)
//   spike_fire       : one-cycle spike launch
//   syndrome_taken   : mesh-wide syndrome generation enable
//   busy, done       : activity / one-cycle round complete
//   match_cnt        : matches this round, saturating
//   err_timeout      : sticky PROP timeout flag
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | syn_ready high, waiting for the frame
// CHECK | look at all_clear: finish or fire another spike
// FIRE  | spike_fire pulse
// PROP  | waiting for spike_taken (optionally bounded)
// GEN   | syndrome_taken held GEN_CYC cycles
// DONE  | done pulse
// -----------------------------------------------------------------------------
module edu_round_ctrl
  import edu_round_ctrl_pkg::*;
#(
  parameter int MAX_SPIKE_CYC = 64,
  parameter int GEN_CYC       = 2,
  parameter int ROUND_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               flush,
  input  logic               syn_valid,
  output logic               syn_ready,
  input  logic               all_clear,
  input  logic               spike_taken,
  output logic               spike_fire,
  output logic               syndrome_taken,
  output logic               busy,
  output logic               done,
  output logic [ROUND_W-1:0] match_cnt,
  output logic               err_timeout
);

  localparam int CNT_W = eductrl_cnt_w(MAX_SPIKE_CYC, GEN_CYC);
  localparam logic [CNT_W-1:0] GEN_LD = CNT_W'(GEN_CYC - 1);

  eductrl_state_e     r_state;
  eductrl_state_e     w_state_nxt;
  eductrl_out_t       r_out;
  logic [ROUND_W-1:0] r_match;
  logic [ROUND_W-1:0] w_match_nxt;

  logic               w_gen_load;
  logic               w_cnt_load;
  logic [CNT_W-1:0]   w_cnt_val;
  logic               w_cnt_en;
  logic               w_cnt_tc;

  // The counter is loaded with (cycles - 1) on the way into GEN or PROP so
  // its terminal count marks the last cycle of the interval.
  assign w_gen_load = (r_state == EDUCTRL_PROP) && spike_taken;

`ifdef EDU_TIMEOUT_EN
  localparam logic [CNT_W-1:0] MAX_LD = CNT_W'(MAX_SPIKE_CYC - 1);

  logic r_err;
  logic w_err_nxt;

  assign w_cnt_load = w_gen_load || (r_state == EDUCTRL_FIRE);
  assign w_cnt_val  = w_gen_load ? GEN_LD : MAX_LD;
  assign w_cnt_en   = (r_state == EDUCTRL_GEN) || (r_state == EDUCTRL_PROP);
`else
  assign w_cnt_load = w_gen_load;
  assign w_cnt_val  = GEN_LD;
  assign w_cnt_en   = (r_state == EDUCTRL_GEN);
`endif

  edu_round_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (flush),
    .i_load   (w_cnt_load),
    .i_ld_val (w_cnt_val),
    .i_en     (w_cnt_en),
    .o_tc     (w_cnt_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
`ifdef EDU_TIMEOUT_EN
    w_err_nxt   = r_err;
`endif
    if (flush) begin
      // Abort keeps match count and error flag for post-mortem.
      w_state_nxt = EDUCTRL_IDLE;
    end else begin
      case (r_state)
        EDUCTRL_IDLE: begin
          if (start) begin
            w_state_nxt = EDUCTRL_LOAD;
            w_match_nxt = '0;
`ifdef EDU_TIMEOUT_EN
            w_err_nxt   = 1'b0;
`endif
          end
        end
        EDUCTRL_LOAD: begin
          if (syn_valid) w_state_nxt = EDUCTRL_CHECK;
        end
        EDUCTRL_CHECK: begin
          w_state_nxt = all_clear ? EDUCTRL_DONE : EDUCTRL_FIRE;
        end
        EDUCTRL_FIRE: begin
          w_state_nxt = EDUCTRL_PROP;
        end
        EDUCTRL_PROP: begin
          // A spike taken on the expiry cycle still counts as a match.
          if (spike_taken) begin
            w_state_nxt = EDUCTRL_GEN;
            if (r_match != '1) w_match_nxt = r_match + 1'b1;
          end
`ifdef EDU_TIMEOUT_EN
          else if (w_cnt_tc) begin
            w_state_nxt = EDUCTRL_DONE;
            w_err_nxt   = 1'b1;
          end
`endif
        end
        EDUCTRL_GEN: begin
          if (w_cnt_tc) w_state_nxt = EDUCTRL_CHECK;
        end
        EDUCTRL_DONE: begin
          w_state_nxt = EDUCTRL_IDLE;
        end
        default: begin
          w_state_nxt = EDUCTRL_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EDUCTRL_IDLE;
      r_out   <= '0;
      r_match <= '0;
`ifdef EDU_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_out   <= eductrl_decode(w_state_nxt);
      r_match <= w_match_nxt;
`ifdef EDU_TIMEOUT_EN
      r_err   <= w_err_nxt;
`endif
    end
  end

  assign syn_ready      = r_out.syn_ready;
  assign spike_fire     = r_out.spike_fire;
  assign syndrome_taken = r_out.syndrome_taken;
  assign busy           = r_out.busy;
  assign done           = r_out.done;
  assign match_cnt      = r_match;

`ifdef EDU_TIMEOUT_EN
  assign err_timeout = r_err;
`else
  assign err_timeout = 1'b0;
`endif

endmodule
